// File: rtl/axi_adder_arbiter.sv
// Four-requester round-robin packet arbiter feeding one registered AXI-style output stream.
// A granted packet holds the output until its last beat, or until MAX_BEATS beats have passed.
module axi_adder_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int MAX_BEATS  = 256
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  s00_axi_wvalid,
    output logic                  s00_axi_wready,
    input  logic [DATA_WIDTH-1:0] s00_axi_wdata,
    input  logic                  s00_axi_wlast,
    input  logic                  s01_axi_wvalid,
    output logic                  s01_axi_wready,
    input  logic [DATA_WIDTH-1:0] s01_axi_wdata,
    input  logic                  s01_axi_wlast,
    input  logic                  s20_axi_wvalid,
    output logic                  s20_axi_wready,
    input  logic [DATA_WIDTH-1:0] s20_axi_wdata,
    input  logic                  s20_axi_wlast,
    input  logic                  s21_axi_wvalid,
    output logic                  s21_axi_wready,
    input  logic [DATA_WIDTH-1:0] s21_axi_wdata,
    input  logic                  s21_axi_wlast,
    input  logic [3:0]            ch_enable,
    output logic                  m00_axi_rvalid,
    input  logic                  m00_axi_rready,
    output logic [DATA_WIDTH-1:0] m00_axi_rdata,
    output logic                  m00_axi_rlast,
    output logic [1:0]            m00_grant,
    output logic                  busy,
    output logic                  trunc_err
);

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;

    localparam logic [15:0] LP_LAST_BEAT = 16'(MAX_BEATS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_rr_ptr;
    logic [1:0]            r_grant;
    logic [15:0]           r_beat_cnt;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rlast;
    logic [1:0]            r_ogrant;
    logic                  r_trunc;

    logic [3:0]            w_wvalid;
    logic [3:0]            w_wlast;
    logic [3:0]            w_req;
    logic [3:0]            w_wready;
    logic [DATA_WIDTH-1:0] w_wdata [4];
    logic [1:0]            w_pick;
    logic [1:0]            w_idx;
    logic                  w_found;
    logic                  w_out_free;
    logic                  w_accept;
    logic                  w_forced;
    logic                  w_rlast_nxt;

    assign w_wvalid   = {s21_axi_wvalid, s20_axi_wvalid, s01_axi_wvalid, s00_axi_wvalid};
    assign w_wlast    = {s21_axi_wlast, s20_axi_wlast, s01_axi_wlast, s00_axi_wlast};
    assign w_wdata[0] = s00_axi_wdata;
    assign w_wdata[1] = s01_axi_wdata;
    assign w_wdata[2] = s20_axi_wdata;
    assign w_wdata[3] = s21_axi_wdata;
    assign w_req      = w_wvalid & ch_enable;

    // Scan from the farthest offset down so the nearest requester after rr_ptr wins.
    always_comb begin
        w_pick  = r_rr_ptr;
        w_found = 1'b0;
        w_idx   = r_rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_rr_ptr + 2'(k);
            if (w_req[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_out_free  = !r_rvalid || m00_axi_rready;
    assign w_accept    = (r_state == ST_LOCK) && w_wvalid[r_grant] && w_out_free;
    assign w_forced    = (r_beat_cnt == LP_LAST_BEAT);
    assign w_rlast_nxt = w_wlast[r_grant] || w_forced;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_found) w_state_nxt = ST_LOCK;
            ST_LOCK: if (w_accept && w_rlast_nxt) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_wready = 4'b0000;
        busy     = 1'b0;
        if (r_state == ST_LOCK) begin
            w_wready[r_grant] = w_out_free;
            busy              = 1'b1;
        end
    end

    assign s00_axi_wready = w_wready[0];
    assign s01_axi_wready = w_wready[1];
    assign s20_axi_wready = w_wready[2];
    assign s21_axi_wready = w_wready[3];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr   <= 2'd0;
            r_grant    <= 2'd0;
            r_beat_cnt <= 16'd0;
        end else begin
            if (r_state == ST_IDLE && w_found) begin
                r_grant <= w_pick;
            end
            if (w_accept) begin
                if (w_rlast_nxt) begin
                    r_beat_cnt <= 16'd0;
                    r_rr_ptr   <= r_grant + 2'd1;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 16'd1;
                end
            end
        end
    end

    // Output register: a new beat may load in the same cycle the held one drains.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rlast  <= 1'b0;
            r_ogrant <= 2'd0;
            r_trunc  <= 1'b0;
        end else begin
            r_trunc <= w_accept && w_forced && !w_wlast[r_grant];
            if (w_accept) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_wdata[r_grant];
                r_rlast  <= w_rlast_nxt;
                r_ogrant <= r_grant;
            end else if (m00_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign m00_axi_rvalid = r_rvalid;
    assign m00_axi_rdata  = r_rdata;
    assign m00_axi_rlast  = r_rlast;
    assign m00_grant      = r_ogrant;
    assign trunc_err      = r_trunc;

endmodule

// File: tb/tb_axi_adder_arbiter.sv
// Randomized bench for axi_adder_arbiter: per-channel packet queues feed the DUT while a
// packet-level round-robin model predicts the exact output beat stream.
module tb_axi_adder_arbiter;

    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [3:0]    tb_wvalid = 4'b0000;
    logic [3:0]    tb_wlast = 4'b0000;
    logic [DW-1:0] tb_wdata [4];
    logic [3:0]    ch_enable = 4'b0000;
    logic          rready = 1'b0;
    logic          wr0, wr1, wr2, wr3;
    logic [3:0]    tb_wready;
    logic          rvalid, rlast, busy, trunc;
    logic [DW-1:0] rdata;
    logic [1:0]    ogrant;

    assign tb_wready = {wr3, wr2, wr1, wr0};

    axi_adder_arbiter #(.DATA_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
        .clock(clock), .resetn(resetn),
        .s00_axi_wvalid(tb_wvalid[0]), .s00_axi_wready(wr0), .s00_axi_wdata(tb_wdata[0]), .s00_axi_wlast(tb_wlast[0]),
        .s01_axi_wvalid(tb_wvalid[1]), .s01_axi_wready(wr1), .s01_axi_wdata(tb_wdata[1]), .s01_axi_wlast(tb_wlast[1]),
        .s20_axi_wvalid(tb_wvalid[2]), .s20_axi_wready(wr2), .s20_axi_wdata(tb_wdata[2]), .s20_axi_wlast(tb_wlast[2]),
        .s21_axi_wvalid(tb_wvalid[3]), .s21_axi_wready(wr3), .s21_axi_wdata(tb_wdata[3]), .s21_axi_wlast(tb_wlast[3]),
        .ch_enable(ch_enable),
        .m00_axi_rvalid(rvalid), .m00_axi_rready(rready), .m00_axi_rdata(rdata), .m00_axi_rlast(rlast),
        .m00_grant(ogrant), .busy(busy), .trunc_err(trunc)
    );

    always #5 clock = ~clock;

    // chq: what the bench still has to drive; mq: the model's copy of the same packets.
    logic [32:0] chq [4][$];
    logic [32:0] mq  [4][$];
    logic [34:0] exp_q [$];
    int          seg_cnt [4];
    int          m_ptr = 0;
    int          n_cmp = 0, n_err = 0;
    int          n_trunc = 0, exp_trunc = 0;
    int          cyc = 0, last_out_cyc = -1;
    int          stall_pct = 0, stall_left = 0;
    bit          stall_trig = 0, bubbles = 0, gap_mode = 0, chk_out = 1, en_drop = 0;
    bit          prev_stall = 0, prev_trunc = 0;
    logic [34:0] prev_word = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_pkt(input int ch, input int len, input logic [31:0] base, input bit rnd);
        logic [32:0] ent;
        for (int i = 0; i < len; i++) begin
            ent = {(i == len - 1), (rnd ? 32'($urandom()) : base + 32'(i))};
            chq[ch].push_back(ent);
            mq[ch].push_back(ent);
        end
    endtask

    // Round robin over whole packets; a packet longer than MAXB is split and its tail re-arbitrates.
    task automatic plan(input logic [3:0] en);
        int          ch, n;
        bit          done, forced, lst;
        logic [32:0] ent;
        while (1) begin
            ch = -1;
            for (int k = 0; k < 4; k++) begin
                int c = (m_ptr + k) % 4;
                if (ch < 0 && en[c] && mq[c].size() > 0) ch = c;
            end
            if (ch < 0) break;
            n = 0;
            done = 0;
            while (!done) begin
                ent = mq[ch].pop_front();
                n++;
                forced = (n == MAXB);
                lst = ent[32] || forced;
                if (forced && !ent[32]) exp_trunc++;
                exp_q.push_back({2'(ch), lst, ent[31:0]});
                done = lst || (mq[ch].size() == 0);
            end
            m_ptr = (ch + 1) % 4;
        end
    endtask

    task automatic drive();
        logic [32:0] ent;
        for (int ch = 0; ch < 4; ch++) begin
            if (chq[ch].size() > 0) begin
                ent = chq[ch][0];
                tb_wvalid[ch] = (seg_cnt[ch] == 0 || !bubbles) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end else begin
                ent = {1'b0, 32'($urandom())};
                tb_wvalid[ch] = 1'b0;
            end
            tb_wdata[ch] = ent[31:0];
            tb_wlast[ch] = ent[32];
        end
        if (stall_left > 0) begin
            rready = 1'b0;
            stall_left--;
        end else begin
            rready = ($urandom_range(0, 99) >= stall_pct);
        end
    endtask

    task automatic sample();
        logic [34:0] word;
        logic [32:0] ent;
        cyc++;
        word = {ogrant, rlast, rdata};
        for (int ch = 0; ch < 4; ch++) begin
            if (tb_wvalid[ch] && tb_wready[ch] && chq[ch].size() > 0) begin
                ent = chq[ch].pop_front();
                seg_cnt[ch]++;
                if (ent[32] || seg_cnt[ch] == MAXB) seg_cnt[ch] = 0;
                if (en_drop && ch == 1) begin
                    ch_enable[1] = 1'b0;
                    en_drop = 0;
                end
            end
        end
        if (|tb_wready) begin
            check_eq("wready_onehot", $countones(tb_wready), 1);
            check_eq("wready_backpressure", rvalid && !rready, 0);
            check_eq("busy_in_lock", busy, 1);
        end
        if (prev_stall) begin
            check_eq("hold_valid", rvalid, 1);
            check_eq("hold_beat", word, prev_word);
        end
        if (chk_out && rvalid && rready) begin
            if (exp_q.size() == 0) check_eq("extra_beat", word, 0);
            else check_eq("out_beat", word, exp_q.pop_front());
            if (gap_mode && last_out_cyc >= 0) check_eq("pkt_gap", cyc - last_out_cyc, 2);
            last_out_cyc = cyc;
            if (stall_trig) begin
                stall_left = 5;
                stall_trig = 0;
            end
        end
        if (trunc) begin
            n_trunc++;
            check_eq("trunc_with_last", rvalid && rlast, 1);
            check_eq("trunc_one_cycle", prev_trunc, 0);
        end
        prev_trunc = trunc;
        prev_stall = rvalid && !rready;
        prev_word = word;
    endtask

    task automatic cycle();
        drive();
        @(negedge clock);
        sample();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_model();
        for (int ch = 0; ch < 4; ch++) begin
            chq[ch].delete();
            mq[ch].delete();
            seg_cnt[ch] = 0;
        end
        exp_q.delete();
        m_ptr = 0;
        prev_stall = 0;
        prev_trunc = 0;
        stall_left = 0;
    endtask

    task automatic run_phase(input logic [3:0] en);
        int c = 0;
        ch_enable = en;
        last_out_cyc = -1;
        plan(en);
        while (exp_q.size() > 0 && c < 3000) begin
            cycle();
            c++;
        end
        check_eq("phase_done", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) cycle();
        check_eq("idle_after_phase", busy, 0);
        check_eq("trunc_count", n_trunc, exp_trunc);
    endtask

    task automatic check_zero_outs(input string tag);
        check_eq(tag, {rvalid, rlast, ogrant, busy, trunc, tb_wready, rdata}, 0);
    endtask

    initial begin
        for (int ch = 0; ch < 4; ch++) begin
            tb_wdata[ch] = '0;
            seg_cnt[ch] = 0;
        end
        repeat (3) @(posedge clock);
        #1;
        check_zero_outs("reset_outputs");
        resetn = 1'b1;

        // Four single-beat requesters: grants 0,1,2,3,0 with one idle cycle between packets.
        load_pkt(0, 1, 32'h100, 0);
        load_pkt(1, 1, 32'h110, 0);
        load_pkt(2, 1, 32'h120, 0);
        load_pkt(3, 1, 32'h130, 0);
        load_pkt(0, 1, 32'h140, 0);
        gap_mode = 1;
        run_phase(4'b1111);
        gap_mode = 0;

        // Channel 2 three-beat packet uninterleaved, then channel 3, then channel 0.
        load_pkt(2, 3, 32'hA, 0);
        load_pkt(0, 1, 32'h200, 0);
        load_pkt(3, 1, 32'h300, 0);
        run_phase(4'b1111);

        // Six beats with MAXB=4: cut after beat 4, tail re-arbitrates.
        load_pkt(1, 6, 32'h600, 0);
        run_phase(4'b1111);

        // Five-cycle output stall mid-packet.
        load_pkt(3, 4, 32'h700, 0);
        load_pkt(0, 3, 32'h800, 0);
        stall_trig = 1;
        run_phase(4'b1111);

        // Channel 0 masked off while everyone requests.
        for (int ch = 0; ch < 4; ch++) load_pkt(ch, $urandom_range(1, 3), 0, 1);
        load_pkt(1, 2, 0, 1);
        run_phase(4'b1110);
        // Dropping enable during channel 1's lock must not cut its packet.
        load_pkt(1, 3, 32'h900, 0);
        en_drop = 1;
        run_phase(4'b0010);
        run_phase(4'b1111);

        // Random traffic with back-pressure, requester bubbles and random enable masks.
        bubbles = 1;
        for (int r = 0; r < 8; r++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 1) == 1) load_pkt(ch, $urandom_range(1, 7), 0, 1);
                if ($urandom_range(0, 2) == 0) load_pkt(ch, $urandom_range(1, 7), 0, 1);
            end
            stall_pct = $urandom_range(0, 50);
            run_phase((r == 7) ? 4'b1111 : 4'(($urandom_range(1, 15))));
        end
        run_phase(4'b1111);
        bubbles = 0;
        stall_pct = 0;

        // Reset in the middle of channel 2's packet; the next arbitration starts from channel 0.
        load_pkt(1, 1, 32'hB00, 0);
        run_phase(4'b1111);
        load_pkt(2, 4, 32'hC00, 0);
        chk_out = 0;
        begin
            int c = 0;
            while (seg_cnt[2] < 2 && c < 50) begin
                cycle();
                c++;
            end
            check_eq("reset_setup", seg_cnt[2], 2);
        end
        drive();
        #1;
        check_eq("pre_reset_valid", rvalid, 1);
        #1;
        resetn = 1'b0;
        #1;
        check_zero_outs("async_reset_outputs");
        clear_model();
        chk_out = 1;
        @(posedge clock);
        @(posedge clock);
        #1;
        check_zero_outs("held_reset_outputs");
        load_pkt(0, 1, 32'hD00, 0);
        load_pkt(2, 1, 32'hD20, 0);
        resetn = 1'b1;
        run_phase(4'b1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_adder_arbiter.md
AXI_ADDER_ARBITER -- requirements
Module: axi_adder_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, width of every data bus.
REQ-002 SHALL have parameter MAX_BEATS, default 256, maximum beats per granted packet (range 2..65535).
REQ-003 SHALL have port clock  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports s00_/s01_/s20_/s21_axi_wvalid  in  1 each  requester beat valid; channel index 0/1/2/3 respectively.
REQ-006 SHALL have ports s00_/s01_/s20_/s21_axi_wready  out  1 each  requester beat accepted when valid&ready.
REQ-007 SHALL have ports s00_/s01_/s20_/s21_axi_wdata  in  DATA_WIDTH each  requester beat data.
REQ-008 SHALL have ports s00_/s01_/s20_/s21_axi_wlast  in  1 each  final beat of requester packet.
REQ-009 SHALL have port ch_enable  in  4  per-channel arbitration enable, bit i = channel i.
REQ-010 SHALL have ports m00_axi_rvalid out 1, m00_axi_rready in 1, m00_axi_rdata out DATA_WIDTH, m00_axi_rlast out 1: shared output toward adder.
REQ-011 SHALL have port m00_grant  out  2  channel index owning current output beat.
REQ-012 SHALL have port busy  out  1  high while a packet is locked.
REQ-013 SHALL have port trunc_err  out  1  one-cycle pulse when a packet is cut at MAX_BEATS.

Function
REQ-014 SHALL implement FSM states IDLE and LOCK.
REQ-015 IDLE: all s*_axi_wready SHALL be 0; if any channel has wvalid=1 and ch_enable=1, SHALL select the first such channel searching circularly from rr_ptr, register it as grant, enter LOCK next cycle.
REQ-016 IDLE with no enabled valid requester SHALL remain IDLE.
REQ-017 LOCK: wready of granted channel SHALL equal (!m00_axi_rvalid | m00_axi_rready); all other wready SHALL be 0.
REQ-018 Accepted beat SHALL load rdata, rlast, m00_grant into the output register and set rvalid=1 the following cycle (one-cycle latency input accept to output valid).
REQ-019 While rvalid=1 and rready=0, rdata, rlast, m00_grant SHALL remain stable.
REQ-020 rvalid SHALL clear on rready=1 when no new beat is accepted in that cycle; accept and drain in the same cycle SHALL sustain full throughput.
REQ-021 beat_cnt SHALL count accepted beats of the locked packet, 0 at packet start.
REQ-022 rlast SHALL be wlast | (beat_cnt == MAX_BEATS-1); if forced with wlast=0, trunc_err SHALL pulse high one cycle with that accept.
REQ-023 Accept of a beat with rlast=1 SHALL set rr_ptr to (grant+1) mod 4, clear beat_cnt, return to IDLE; exactly one idle arbitration cycle between packets.
REQ-024 Remainder of a truncated packet SHALL arbitrate as a new packet.
REQ-025 ch_enable SHALL be sampled only in IDLE; deasserting it during LOCK SHALL not interrupt the locked packet.
REQ-026 Granted requester dropping wvalid mid-packet SHALL keep lock, no timeout.
REQ-027 busy SHALL be 1 exactly in LOCK.

Reset
REQ-028 resetn=0 SHALL immediately force state IDLE, rr_ptr=0, beat_cnt=0, grant=0, and all outputs 0 (wready, rvalid, rdata, rlast, m00_grant, busy, trunc_err).
REQ-029 Reset mid-packet SHALL discard the partial packet and the held output beat; first arbitration after release SHALL start from channel 0.

Verification
REQ-030 Post-reset, all four channels valid with 1-beat packets (wlast=1), rready=1 -> output grant order 0,1,2,3,0; each packet one idle cycle apart.
REQ-031 Channel 2 sends 3-beat packet 0xA,0xB,0xC while channel 0 valid -> output 0xA,0xB,0xC with m00_grant=2 uninterleaved, rlast only on 0xC, then channel 3 wins if valid else channel 0.
REQ-032 MAX_BEATS=4, channel 1 sends 6 beats with wlast on beat 6 -> rlast on beat 4, trunc_err single pulse, beats 5-6 delivered as a second packet after arbitration.
REQ-033 rready=0 for 5 cycles mid-packet -> rdata/rlast/m00_grant stable, granted wready=0 after output fills, no beat lost or duplicated on release.
REQ-034 ch_enable=4'b1110 with all channels valid -> channel 0 never granted; clearing bit 1 during channel 1 LOCK -> packet completes.
REQ-035 resetn pulsed low during 3rd beat of a packet -> all outputs 0 asynchronously; after release, channel 0 valid wins first.
